// File: rtl/jtframe_db15_reader.sv
// DB15 adapter reader: drives JOY_LOAD/JOY_CLK, shifts 2*NBITS bits, presents two joystick words.
// Define JTFRAME_DB15_DEBOUNCE_EN to update outputs only after two identical consecutive frames.
module jtframe_db15_reader #(
  parameter int unsigned CLK_DIV   = 24,
  parameter int unsigned NBITS     = 16,
  parameter int unsigned GAP_TICKS = 64
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             JOY_DATA,
  output logic             JOY_CLK,
  output logic             JOY_LOAD,
  output logic [NBITS-1:0] joystick1,
  output logic [NBITS-1:0] joystick2,
  output logic             frame_done
);
  localparam int unsigned FBITS = 2 * NBITS;
  localparam int unsigned IW    = $clog2(FBITS);
  localparam int unsigned GW    = $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {StLoad, StShift, StUpdate, StWait} state_e;

  state_e           state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             phase_q, phase_d;
  logic [FBITS-1:0] sr_q, sr_d;
  logic [NBITS-1:0] joy1_q, joy1_d, joy2_q, joy2_d;
  logic             clk_q, clk_d, load_q, load_d, done_q, done_d;
  logic [1:0]       sync_q;
  logic             tick, data_s, wr_en;

  assign data_s = sync_q[1];
  assign tick   = (div_q == 8'(CLK_DIV - 1));

`ifdef JTFRAME_DB15_DEBOUNCE_EN
  logic [FBITS-1:0] prev_q;

  assign wr_en = (sr_q == prev_q);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      prev_q <= '0;
    end else if (state_q == StUpdate) begin
      prev_q <= sr_q;
    end
  end
`else
  assign wr_en = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = tick ? 8'd0 : div_q + 8'd1;
    gap_d   = gap_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    sr_d    = sr_q;
    joy1_d  = joy1_q;
    joy2_d  = joy2_q;
    clk_d   = clk_q;
    load_d  = load_q;
    done_d  = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (tick) begin
          if (phase_q) begin
            state_d = StShift;
            load_d  = 1'b1;
            idx_d   = '0;
            phase_d = 1'b0;
          end else begin
            phase_d = 1'b1;
          end
        end
      end
      StShift: begin
        if (tick) begin
          if (!phase_q) begin
            // Buttons are active-low on the wire
            sr_d[idx_q] = ~data_s;
            clk_d       = 1'b0;
            phase_d     = 1'b1;
          end else begin
            clk_d   = 1'b1;
            phase_d = 1'b0;
            if (idx_q == IW'(FBITS - 1)) begin
              state_d = StUpdate;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      StUpdate: begin
        if (wr_en) begin
          joy1_d = sr_q[NBITS-1:0];
          joy2_d = sr_q[FBITS-1:NBITS];
          done_d = 1'b1;
        end
        state_d = StWait;
        gap_d   = '0;
      end
      StWait: begin
        // Last high phase ends on the first gap tick
        if (tick) begin
          clk_d = 1'b0;
          if (gap_q == GW'(GAP_TICKS - 1)) begin
            state_d = StLoad;
            gap_d   = '0;
            load_d  = 1'b0;
            phase_d = 1'b0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= StWait;
      div_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      phase_q <= 1'b0;
      sr_q    <= '0;
      joy1_q  <= '0;
      joy2_q  <= '0;
      clk_q   <= 1'b0;
      load_q  <= 1'b1;
      done_q  <= 1'b0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      sr_q    <= sr_d;
      joy1_q  <= joy1_d;
      joy2_q  <= joy2_d;
      clk_q   <= clk_d;
      load_q  <= load_d;
      done_q  <= done_d;
      sync_q  <= {sync_q[0], JOY_DATA};
    end
  end

  assign JOY_CLK    = clk_q;
  assign JOY_LOAD   = load_q;
  assign joystick1  = joy1_q;
  assign joystick2  = joy2_q;
  assign frame_done = done_q;

endmodule
